// File: rtl/pulse_freq_meter_pkg.sv
// Shared definitions for the pulse frequency meter: FSM state encoding,
// default counter width and timer sizing helper.
package pulse_freq_meter_pkg;

  localparam int CNT_W_DEFAULT = 32;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_START = 3'd1,
    ST_GATE       = 3'd2,
    ST_WAIT_STOP  = 3'd3,
    ST_DONE       = 3'd4
  } meas_state_e;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int tmr_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pulse_freq_meter_edge_det.sv
// Rising-edge detector for a signal already synchronous to ad_clk; the
// registered copy starts low so a level high out of reset reads as a rise once.
module pulse_edge_det (
  input  logic ad_clk,
  input  logic rst_n,
  input  logic i_pulse,
  output logic o_rise
);

  logic r_pulse_d;

  // NOTE: clocked state uses <= so every flop samples pre-edge values.
  always_ff @(posedge ad_clk or negedge rst_n) begin
    if (!rst_n) r_pulse_d <= 1'b0;
    else        r_pulse_d <= i_pulse;
  end

  assign o_rise = i_pulse & ~r_pulse_d;

endmodule

// File: rtl/pulse_freq_meter.sv
// Edge-aligned gate frequency meter: the gate opens and closes on ad_pulse
// rising edges and reports edges:clocks for firmware to turn into a frequency.
module pulse_freq_meter
  import pulse_freq_meter_pkg::*;
#(
  parameter int CNT_W          = CNT_W_DEFAULT,
  parameter int GATE_CYCLES    = 25_000_000,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic             ad_clk,
  input  logic             rst_n,
  input  logic             meas_en,
  input  logic             ad_pulse,
  output logic [CNT_W-1:0] edge_cnt,
  output logic [CNT_W-1:0] clk_cnt,
  output logic             meas_valid,
  output logic             meas_timeout,
  output logic             busy
);

  localparam int GATE_W = tmr_width(GATE_CYCLES + 1);
  localparam int TO_W   = tmr_width(TIMEOUT_CYCLES);
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

  meas_state_e       r_state, w_state_n;
  logic [CNT_W-1:0]  r_acc_edges, w_acc_edges_n, w_edges_inc;
  logic [CNT_W-1:0]  r_acc_clks, w_acc_clks_n, w_clks_inc;
  logic [GATE_W-1:0] r_gate_tmr, w_gate_tmr_n;
  logic [TO_W-1:0]   r_to_tmr, w_to_tmr_n;
  logic              w_rise, w_timeout;

  logic [CNT_W-1:0]  r_edge_cnt, r_clk_cnt;
  logic              r_meas_valid, r_meas_timeout, r_busy;

  pulse_edge_det u_edge_det (
    .ad_clk  (ad_clk),
    .rst_n   (rst_n),
    .i_pulse (ad_pulse),
    .o_rise  (w_rise)
  );

  // Accumulators stick at all-ones rather than wrapping to a bogus small ratio.
  assign w_edges_inc = (&r_acc_edges) ? r_acc_edges : r_acc_edges + CNT_W'(1);
  assign w_clks_inc  = (&r_acc_clks)  ? r_acc_clks  : r_acc_clks  + CNT_W'(1);

  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    w_state_n     = r_state;
    w_acc_edges_n = r_acc_edges;
    w_acc_clks_n  = r_acc_clks;
    w_gate_tmr_n  = r_gate_tmr;
    w_to_tmr_n    = r_to_tmr;
    w_timeout     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (meas_en) begin
          w_state_n  = ST_WAIT_START;
          w_to_tmr_n = '0;
        end
      end
      ST_WAIT_START: begin
        if (w_rise) begin
          w_state_n     = ST_GATE;
          w_acc_edges_n = '0;
          w_acc_clks_n  = '0;
          w_gate_tmr_n  = '0;
        end else if (r_to_tmr == TO_LAST) begin
          w_state_n = ST_IDLE;
          w_timeout = 1'b1;
        end else begin
          w_to_tmr_n = r_to_tmr + TO_W'(1);
        end
      end
      ST_GATE: begin
        w_acc_clks_n = w_clks_inc;
        w_gate_tmr_n = r_gate_tmr + GATE_W'(1);
        if (w_rise) w_acc_edges_n = w_edges_inc;
        // A rise on the final gate cycle is a gate edge, never the stop edge.
        if (r_gate_tmr == GATE_LAST) begin
          w_state_n  = ST_WAIT_STOP;
          w_to_tmr_n = '0;
        end
      end
      ST_WAIT_STOP: begin
        w_acc_clks_n = w_clks_inc;
        if (w_rise) begin
          w_acc_edges_n = w_edges_inc;
          w_state_n     = ST_DONE;
        end else if (r_to_tmr == TO_LAST) begin
          w_state_n = ST_IDLE;
          w_timeout = 1'b1;
        end else begin
          w_to_tmr_n = r_to_tmr + TO_W'(1);
        end
      end
      ST_DONE: begin
        w_state_n  = ST_WAIT_START;
        w_to_tmr_n = '0;
      end
      default: w_state_n = ST_IDLE;
    endcase

    // Dropping meas_en wins over any rise or timeout seen in the same cycle.
    if (!meas_en && (r_state != ST_IDLE)) begin
      w_state_n = ST_IDLE;
      w_timeout = 1'b0;
    end
  end

  always_ff @(posedge ad_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_acc_edges <= '0;
      r_acc_clks  <= '0;
      r_gate_tmr  <= '0;
      r_to_tmr    <= '0;
    end else begin
      r_state     <= w_state_n;
      r_acc_edges <= w_acc_edges_n;
      r_acc_clks  <= w_acc_clks_n;
      r_gate_tmr  <= w_gate_tmr_n;
      r_to_tmr    <= w_to_tmr_n;
    end
  end

  // Outputs load from next-state values so they line up with the DONE cycle.
  always_ff @(posedge ad_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_edge_cnt     <= '0;
      r_clk_cnt      <= '0;
      r_meas_valid   <= 1'b0;
      r_meas_timeout <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_meas_valid   <= (w_state_n == ST_DONE);
      r_meas_timeout <= w_timeout;
      r_busy         <= (w_state_n != ST_IDLE);
      if (w_state_n == ST_DONE) begin
        r_edge_cnt <= w_acc_edges_n;
        r_clk_cnt  <= w_acc_clks_n;
      end
    end
  end

  assign edge_cnt     = r_edge_cnt;
  assign clk_cnt      = r_clk_cnt;
  assign meas_valid   = r_meas_valid;
  assign meas_timeout = r_meas_timeout;
  assign busy         = r_busy;

endmodule
